io_bus_responder: RTL and testbench

// - Read-side (responder) end of the core's memory-mapped I/O bus; supplies bus_rdata for loads
//   and accepts stores to its own register window. Replaces the constant-zero read path.
// - Owns button input (synchronise, debounce, sticky rising-edge flags), the LED register, a

---
 rtl/io_bus_responder_pkg.sv | 27 ++
 rtl/io_bus_responder_if.sv | 19 +
 rtl/io_bus_responder_btn_debounce.sv | 45 ++++
 rtl/io_bus_responder.sv | 102 ++++++++++
 tb/tb_io_bus_responder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_responder_pkg.sv
// Shared register-window definitions for the I/O bus responder: base address,
// register selectors and address decode helpers.
package io_bus_responder_pkg;

  localparam logic [31:0] IO_BASE = 32'h0001_1000;

  // Word index inside the 32-byte window (bus_addr[4:2]).
  typedef enum logic [2:0] {
    REG_BTN_STATE = 3'd0,
    REG_BTN_EDGE  = 3'd1,
    REG_LED       = 3'd2,
    REG_CYCLES    = 3'd3,
    REG_FRAMES    = 3'd4,
    REG_SCRATCH   = 3'd5,
    REG_RSVD_6    = 3'd6,
    REG_RSVD_7    = 3'd7
  } reg_sel_e;

  function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:5] == base[31:5];
  endfunction

  function automatic reg_sel_e reg_sel(input logic [31:0] addr);
    return reg_sel_e'(addr[4:2]);
  endfunction

endpackage

// File: rtl/io_bus_responder_if.sv
// Memory-mapped I/O bus between the core (master) and a read-side responder (slave).
interface io_bus_responder_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/io_bus_responder_btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser followed by a stability counter.
// rise pulses on the same cycle the accepted state goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic state,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;

  assign accept = (sync2_reg != state_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      // Any sample matching the current state restarts the stability window.
      if (sync2_reg == state_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        state_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign state = state_reg;
  assign rise  = accept & sync2_reg;
endmodule

// File: rtl/io_bus_responder.sv
// I/O register window on the core's memory-mapped bus: buttons, LEDs, cycle and
// frame counters, scratch register. Loads answer one cycle later; rdata is 0 when idle.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = IO_BASE,
  parameter int          NUM_BTNS        = 5,
  parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  io_bus_responder_if.slave   bus,
  input  logic [NUM_BTNS-1:0] btns,
  input  logic                frame_trig,
  output logic [15:0]         led
);
  logic [NUM_BTNS-1:0] btn_state;
  logic [NUM_BTNS-1:0] btn_rise;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btns[gi]),
        .state  (btn_state[gi]),
        .rise   (btn_rise[gi])
      );
    end
  endgenerate

  logic                hit;
  logic                wr_en;
  logic                rd_en;
  reg_sel_e            sel;
  logic [31:0]         rd_value;
  logic [NUM_BTNS-1:0] edge_clr;
  logic [NUM_BTNS-1:0] edge_next;

  logic [NUM_BTNS-1:0] edge_reg;
  logic [15:0]         led_reg;
  logic [31:0]         cycles_reg;
  logic [31:0]         frames_reg;
  logic [31:0]         scratch_reg;
  logic [31:0]         rdata_reg;
  logic                rvalid_reg;

  assign hit   = window_hit(bus.bus_addr, BASE_ADDR);
  assign sel   = reg_sel(bus.bus_addr);
  assign wr_en = bus.bus_we & hit;
  assign rd_en = bus.bus_re & hit;

  // A rise landing on the same edge as a W1C clear must survive, so OR it in last.
  assign edge_clr  = (wr_en && sel == REG_BTN_EDGE) ? bus.bus_wdata[NUM_BTNS-1:0] : '0;
  assign edge_next = (edge_reg & ~edge_clr) | btn_rise;

  always_comb begin
    rd_value = '0;
    case (sel)
      REG_BTN_STATE: rd_value = 32'(btn_state);
      REG_BTN_EDGE:  rd_value = 32'(edge_reg);
      REG_LED:       rd_value = {16'h0000, led_reg};
      REG_CYCLES:    rd_value = cycles_reg;
      REG_FRAMES:    rd_value = frames_reg;
      REG_SCRATCH:   rd_value = scratch_reg;
      default:       rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_reg    <= '0;
      led_reg     <= '0;
      cycles_reg  <= '0;
      frames_reg  <= '0;
      scratch_reg <= '0;
      rdata_reg   <= '0;
      rvalid_reg  <= 1'b0;
    end else begin
      cycles_reg <= cycles_reg + 32'd1;
      if (frame_trig) begin
        frames_reg <= frames_reg + 32'd1;
      end
      edge_reg <= edge_next;
      if (wr_en && sel == REG_LED) begin
        led_reg <= bus.bus_wdata[15:0];
      end
      if (wr_en && sel == REG_SCRATCH) begin
        scratch_reg <= bus.bus_wdata;
      end
      // rd_value reflects pre-write state, so a combined load/store returns the old value.
      rvalid_reg <= rd_en;
      rdata_reg  <= rd_en ? rd_value : '0;
    end
  end

  assign bus.bus_rdata  = rdata_reg;
  assign bus.bus_rvalid = rvalid_reg;
  assign led            = led_reg;
endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed scenarios plus a randomized
// run, all checked against a cycle-level register-map model kept in the bench.
module tb_io_bus_responder;
  localparam logic [31:0] BASE = 32'h0001_1000;
  localparam int          NB   = 5;
  localparam int          DB   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btns = '0;
  logic          frame_trig = 1'b0;
  logic [15:0]   led;

  io_bus_responder_if bus_if();

  io_bus_responder #(
    .BASE_ADDR      (BASE),
    .NUM_BTNS       (NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .btns      (btns),
    .frame_trig(frame_trig),
    .led       (led)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents as the specification describes them.
  logic [15:0]   m_led;
  logic [31:0]   m_scratch, m_cycles, m_frames;
  logic [NB-1:0] m_state, m_edge;
  logic [NB-1:0] raw_q[$];   // raw samples still in flight through the synchroniser
  logic [NB-1:0] seen_q[$];  // last DB samples presented to the debouncer since reset
  logic          exp_rvalid;
  logic [31:0]   exp_rdata;

  function automatic logic [31:0] model_read(input logic [31:0] off);
    case (off)
      32'h00:  return 32'(m_state);
      32'h04:  return 32'(m_edge);
      32'h08:  return {16'h0, m_led};
      32'h0C:  return m_cycles;
      32'h10:  return m_frames;
      32'h14:  return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock, updating the model from the inputs present at that edge.
  task automatic tick();
    logic          hitv;
    logic [31:0]   off;
    logic [NB-1:0] sample, rise, clr;
    logic          all_diff;
    hitv = (bus_if.bus_addr & 32'hFFFF_FFE0) == BASE;
    off  = bus_if.bus_addr & 32'h0000_001C;
    if (!rst) begin
      m_led = '0; m_scratch = '0; m_cycles = '0; m_frames = '0;
      m_state = '0; m_edge = '0;
      raw_q = '{'0, '0};
      seen_q.delete();
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
    end else begin
      exp_rvalid = bus_if.bus_re && hitv;
      exp_rdata  = exp_rvalid ? model_read(off) : 32'h0;
      raw_q.push_back(btns);
      sample = raw_q.pop_front();
      seen_q.push_back(sample);
      if (seen_q.size() > DB) void'(seen_q.pop_front());
      rise = '0;
      if (seen_q.size() == DB) begin
        for (int b = 0; b < NB; b++) begin
          all_diff = 1'b1;
          foreach (seen_q[k]) if (seen_q[k][b] == m_state[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_state[b] = ~m_state[b];
            rise[b] = m_state[b];
          end
        end
      end
      clr = (bus_if.bus_we && hitv && off == 32'h04) ? bus_if.bus_wdata[NB-1:0] : '0;
      m_edge = (m_edge & ~clr) | rise;
      if (bus_if.bus_we && hitv && off == 32'h08) m_led = bus_if.bus_wdata[15:0];
      if (bus_if.bus_we && hitv && off == 32'h14) m_scratch = bus_if.bus_wdata;
      m_cycles = m_cycles + 1;
      if (frame_trig) m_frames = m_frames + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.bus_we = 1'b0;
    bus_if.bus_re = 1'b0;
    bus_if.bus_addr = 32'h0;
    bus_if.bus_wdata = 32'h0;
  endtask

  task automatic do_load(input logic [31:0] addr);
    bus_if.bus_addr = addr; bus_if.bus_re = 1'b1; bus_if.bus_we = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    bus_if.bus_addr = addr; bus_if.bus_wdata = data; bus_if.bus_we = 1'b1; bus_if.bus_re = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b0;
    idle_ticks(3);
    vectors++;
    if (led !== 16'h0) begin miscompares++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
    vectors++;
    if (bus_if.bus_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", bus_if.bus_rvalid); end
    vectors++;
    if (bus_if.bus_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", bus_if.bus_rdata); end
    rst = 1'b1;
    do_load(BASE + 32'h0C);
    $display("reset: load CYCLES rvalid=%b rdata=%h", bus_if.bus_rvalid, bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rvalid !== 1'b1 || bus_if.bus_rdata !== exp_rdata || bus_if.bus_rdata > 32'd3) begin
      miscompares++;
      $display("FAIL reset_cycles: got v=%b %h want v=1 %h", bus_if.bus_rvalid, bus_if.bus_rdata, exp_rdata);
    end
  endtask

  task automatic test_led();
    do_store(BASE + 32'h08, 32'hABCD_1234);
    $display("led: store ABCD1234 led=%h", led);
    vectors++;
    if (led !== 16'h1234) begin miscompares++; $display("FAIL led_store: got %h want 1234", led); end
    do_load(BASE + 32'h08);
    $display("led: load rvalid=%b rdata=%h", bus_if.bus_rvalid, bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rvalid !== 1'b1 || bus_if.bus_rdata !== 32'h0000_1234) begin
      miscompares++; $display("FAIL led_load: got v=%b %h want v=1 00001234", bus_if.bus_rvalid, bus_if.bus_rdata);
    end
    tick();
    vectors++;
    if (bus_if.bus_rvalid !== 1'b0 || bus_if.bus_rdata !== 32'h0) begin
      miscompares++; $display("FAIL led_idle: got v=%b %h want v=0 0", bus_if.bus_rvalid, bus_if.bus_rdata);
    end
  endtask

  task automatic test_buttons();
    btns[2] = 1'b1;
    idle_ticks(10);
    do_load(BASE + 32'h00);
    $display("btn: state=%h", bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rdata !== 32'h4 || bus_if.bus_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL btn_state: got %h want %h", bus_if.bus_rdata, 32'h4);
    end
    do_load(BASE + 32'h04);
    $display("btn: edge=%h", bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rdata !== 32'h4) begin miscompares++; $display("FAIL btn_edge: got %h want 4", bus_if.bus_rdata); end
    btns[2] = 1'b0;
    idle_ticks(2);
    btns[2] = 1'b1;
    idle_ticks(8);
    do_load(BASE + 32'h00);
    $display("btn: after glitch state=%h", bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rdata !== 32'h4) begin miscompares++; $display("FAIL btn_glitch: got %h want 4", bus_if.bus_rdata); end
  endtask

  task automatic test_w1c_race();
    btns[2] = 1'b0;
    idle_ticks(10);
    do_store(BASE + 32'h04, 32'h4);
    do_load(BASE + 32'h04);
    $display("w1c: after clear edge=%h", bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rdata !== 32'h0) begin miscompares++; $display("FAIL w1c_clear: got %h want 0", bus_if.bus_rdata); end
    // The new level is accepted on the sixth edge after it is applied.
    btns[2] = 1'b1;
    idle_ticks(5);
    do_store(BASE + 32'h04, 32'h4);
    do_load(BASE + 32'h04);
    $display("w1c: race edge=%h", bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rdata !== 32'h4 || bus_if.bus_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL w1c_race: got %h want 4 (model %h)", bus_if.bus_rdata, exp_rdata);
    end
  endtask

  task automatic test_frames();
    for (int i = 0; i < 3; i++) begin
      frame_trig = 1'b1; tick();
      frame_trig = 1'b0; idle_ticks(2);
    end
    do_load(BASE + 32'h10);
    $display("frames: %h", bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rdata !== 32'h3) begin miscompares++; $display("FAIL frames: got %h want 3", bus_if.bus_rdata); end
    do_load(32'h0001_2000);
    $display("miss: rvalid=%b rdata=%h", bus_if.bus_rvalid, bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rvalid !== 1'b0 || bus_if.bus_rdata !== 32'h0) begin
      miscompares++; $display("FAIL miss_load: got v=%b %h want v=0 0", bus_if.bus_rvalid, bus_if.bus_rdata);
    end
    do_store(32'h0001_2014, 32'hDEAD_BEEF);
    do_load(BASE + 32'h14);
    vectors++;
    if (bus_if.bus_rdata !== exp_rdata) begin miscompares++; $display("FAIL miss_store: got %h want %h", bus_if.bus_rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    v = $urandom;
    do_store(BASE + 32'h14, v);
    bus_if.bus_re = 1'b1;
    bus_if.bus_addr = BASE + 32'h00;
    tick();
    $display("b2b: load0 v=%b %h", bus_if.bus_rvalid, bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rvalid !== 1'b1 || bus_if.bus_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL b2b_first: got v=%b %h want v=1 %h", bus_if.bus_rvalid, bus_if.bus_rdata, exp_rdata);
    end
    bus_if.bus_addr = BASE + 32'h14;
    tick();
    bus_idle();
    $display("b2b: load1 v=%b %h", bus_if.bus_rvalid, bus_if.bus_rdata);
    vectors++;
    if (bus_if.bus_rvalid !== 1'b1 || bus_if.bus_rdata !== v) begin
      miscompares++; $display("FAIL b2b_second: got v=%b %h want v=1 %h", bus_if.bus_rvalid, bus_if.bus_rdata, v);
    end
    // Combined store and load returns the pre-write contents.
    bus_if.bus_addr = BASE + 32'h14; bus_if.bus_wdata = ~v;
    bus_if.bus_we = 1'b1; bus_if.bus_re = 1'b1;
    tick();
    bus_idle();
    vectors++;
    if (bus_if.bus_rdata !== v) begin miscompares++; $display("FAIL rw_same: got %h want %h", bus_if.bus_rdata, v); end
    do_load(BASE + 32'h14);
    vectors++;
    if (bus_if.bus_rdata !== ~v) begin miscompares++; $display("FAIL rw_after: got %h want %h", bus_if.bus_rdata, ~v); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst = (i >= 200 && i < 202) ? 1'b0 : 1'b1;
      bus_if.bus_re = 1'($urandom_range(0, 1));
      bus_if.bus_we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) bus_if.bus_addr = $urandom;
      else bus_if.bus_addr = BASE | ($urandom & 32'h1F);
      bus_if.bus_wdata = $urandom;
      frame_trig = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) btns = btns ^ NB'(1 << $urandom_range(0, NB - 1));
      tick();
      vectors++;
      if (bus_if.bus_rvalid !== exp_rvalid || bus_if.bus_rdata !== exp_rdata || led !== m_led) begin
        miscompares++; bad++;
        $display("FAIL random[%0d]: got v=%b d=%h led=%h want v=%b d=%h led=%h", i,
                 bus_if.bus_rvalid, bus_if.bus_rdata, led, exp_rvalid, exp_rdata, m_led);
      end
    end
    bus_idle();
    rst = 1'b1;
    $display("random: 400 cycles, %0d bad", bad);
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_led();
    test_buttons();
    test_w1c_race();
    test_frames();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
